// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are captured on start, summed one bit per
// clock LSB-first, and the result/carry are published together with a one-cycle done.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // state | meaning
   // IDLE  | waiting for start; outputs hold the last result
   // RUN   | one operand bit pair added per clock, LSB first
   // DONE  | result valid, done pulses for this single cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             bit_sum;
   logic             carry_nxt;
   logic             last;

   assign bit_sum   = sh_a[0] ^ sh_b[0] ^ carry;
   assign carry_nxt = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
   assign res_nxt   = {bit_sum, res[WIDTH-1:1]};
   assign last      = (cnt == LAST_BIT);

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= b;
                  carry <= 1'b0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               res   <= res_nxt;
               carry <= carry_nxt;
               cnt   <= cnt + 1'b1;
               // sum/cout only move on the final bit so they stay stable during RUN
               if (last) begin
                  sum  <= res_nxt;
                  cout <= carry_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 busy  output  1  high while the addition is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse marking a new valid result.
REQ-009 sum  output  WIDTH  registered result, A+B modulo 2^WIDTH.
REQ-010 cout  output  1  registered carry-out of the addition.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE, encoded in a registered state variable.
REQ-012 IDLE: start=1 at a rising edge SHALL capture a, b into internal shift registers, clear the internal carry flop, clear the bit counter, and move to RUN.
REQ-013 IDLE: start=0 SHALL leave all registers unchanged.
REQ-014 RUN: each edge SHALL add the LSBs of the shift registers plus the carry flop, computing bit sum = x^y^c and carry = (x&y)|(c&(x^y)).
REQ-015 RUN: each edge SHALL shift both operand registers right by one and shift the sum bit into the MSB of an internal result register.
REQ-016 RUN: the bit counter SHALL increment each edge; on the edge processing bit WIDTH-1 the FSM SHALL move to DONE.
REQ-017 On that same edge, sum SHALL load the completed result and cout SHALL load the final carry.
REQ-018 DONE: done=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH (WIDTH+1 cycles from start to done).
REQ-020 busy SHALL be 1 exactly in RUN, 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in RUN and DONE; operands applied then SHALL have no effect.
REQ-022 sum and cout SHALL hold their last loaded value until the next completion; they SHALL NOT change during RUN.
REQ-023 a, b SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.
REQ-024 Back-to-back: start held high continuously SHALL yield a new acceptance on the edge leaving DONE->IDLE+1, i.e. one operation every WIDTH+2 cycles.
REQ-025 Arithmetic SHALL be unsigned; overflow appears only in cout, sum wraps modulo 2^WIDTH.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the carry flop, counter and shift registers.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL be produced for it and sum/cout SHALL read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, start pulse -> done after 9 cycles, sum=0x00, cout=0, busy high for 8 cycles.
REQ-030 a=0x5A, b=0x3C -> sum=0x96, cout=0; a=0xFF, b=0x01 -> sum=0x00, cout=1.
REQ-031 a=0xFF, b=0xFF -> sum=0xFE, cout=1; then change a, b and pulse start during RUN -> result unchanged, no extra done.
REQ-032 rst_n low for 1 ns at cycle 4 of an 0x5A+0x3C run -> outputs 0 immediately, no done pulse; subsequent 0x01+0x02 -> sum=0x03, cout=0.
REQ-033 start held high for three operations (0x10+0x20, 0x80+0x80, 0x7F+0x01) -> done pulses every 10 cycles, results 0x30/0, 0x00/1, 0x80/0.
REQ-034 Bench SHALL compare every done against a reference model a+b and print time, a, b, sum, cout on each result.
